// File: rtl/fsm_pulse_logger_if.sv
// Record stream interface between the pulse logger and its consumer.
// rec_valid : head record available (FIFO non-empty)
// rec_ready : consumer accepts the head record this cycle
// rec_len   : head record, pulse length in cycles (0 when empty)
interface fsm_pulse_logger_if #(
  parameter int unsigned LEN_W = 8
);
  logic             rec_valid;
  logic             rec_ready;
  logic [LEN_W-1:0] rec_len;

  modport master (output rec_valid, output rec_len, input rec_ready);
  modport slave  (input rec_valid, input rec_len, output rec_ready);
endinterface

// File: rtl/fsm_pulse_logger.sv
// Pulse logger: measures high pulses of a registered FSM output, counts
// completed pulses, flags pulses that stay high too long and queues
// per-pulse lengths in a first-word-fall-through FIFO.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_en          : allows a new pulse measurement to start
//   i_y_in        : monitored signal (already in the clk domain)
//   i_clr         : clears evt_count, stuck and overflow
//   rec_if        : record stream (valid/ready/len), master side
//   o_evt_count   : completed pulses since reset or clear (saturating)
//   o_stuck       : sticky, a pulse reached TIMEOUT samples
//   o_overflow    : sticky, a record was dropped on a full FIFO
//   o_fifo_full   : FIFO holds DEPTH records
module fsm_pulse_logger #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_y_in,
  input  logic                   i_clr,
  fsm_pulse_logger_if.master     rec_if,
  output logic [CNT_W-1:0]       o_evt_count,
  output logic                   o_stuck,
  output logic                   o_overflow,
  output logic                   o_fifo_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] TIMEOUT_L = LEN_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_STUCK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_len_inc;
  logic             w_push;
  logic             w_stuck_set;

  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;
  logic             r_valid;
  logic             r_full;
  logic             w_pop;
  logic             w_do_push;
  logic             w_drop;

  logic [CNT_W-1:0] r_evt;
  logic             r_stuck;
  logic             r_overflow;

  // Saturating length increment
  assign w_len_inc = (r_len == LEN_MAX) ? r_len : r_len + LEN_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Next-state, length and push/stuck strobes
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_push      = 1'b0;
    w_stuck_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && i_y_in) begin
          w_len_nxt = LEN_W'(1);
          if (TIMEOUT_L == LEN_W'(1)) begin
            w_state_nxt = ST_STUCK;
            w_stuck_set = 1'b1;
          end else begin
            w_state_nxt = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        if (i_y_in) begin
          w_len_nxt = w_len_inc;
          if (w_len_inc == TIMEOUT_L) begin
            w_state_nxt = ST_STUCK;
            w_stuck_set = 1'b1;
          end
        end else begin
          w_push      = 1'b1;
          w_len_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STUCK: begin
        if (i_y_in) begin
          w_len_nxt = w_len_inc;
        end else begin
          w_push      = 1'b1;
          w_len_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_len_nxt   = '0;
      end
    endcase
  end

  // FIFO control: a pop frees the slot a same-edge push needs when full
  assign w_pop     = r_valid && rec_if.rec_ready;
  assign w_do_push = w_push && (!r_full || w_pop);
  assign w_drop    = w_push && r_full && !w_pop;
  assign w_occ_nxt = r_occ + OCC_W'(w_do_push) - OCC_W'(w_pop);

  // FIFO pointers, occupancy and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != '0);
      r_full  <= (w_occ_nxt == OCC_FULL);
    end
  end

  // FIFO storage; contents are masked by r_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= r_len;
  end

  // Event counter and sticky flags; clear wins over same-edge updates
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_evt      <= '0;
      r_stuck    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && (r_evt != CNT_MAX)) r_evt <= r_evt + CNT_W'(1);
      if (w_stuck_set) r_stuck    <= 1'b1;
      if (w_drop)      r_overflow <= 1'b1;
    end
  end

  assign rec_if.rec_valid = r_valid;
  assign rec_if.rec_len   = r_valid ? r_mem[r_rptr] : '0;
  assign o_evt_count      = r_evt;
  assign o_stuck          = r_stuck;
  assign o_overflow       = r_overflow;
  assign o_fifo_full      = r_full;

endmodule

// File: tb/tb_fsm_pulse_logger.sv
// Bench for fsm_pulse_logger: pulse/queue reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fsm_pulse_logger;

  localparam int LEN_W   = 8;
  localparam int CNT_W   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 200;
  localparam int LMAX    = (1 << LEN_W) - 1;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic y   = 1'b0;
  logic clr = 1'b0;
  logic [CNT_W-1:0] evt_count;
  logic stuck, overflow, fifo_full;

  fsm_pulse_logger_if #(.LEN_W(LEN_W)) rif ();

  fsm_pulse_logger #(
    .LEN_W(LEN_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_y_in(y), .i_clr(clr),
    .rec_if(rif), .o_evt_count(evt_count), .o_stuck(stuck),
    .o_overflow(overflow), .o_fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pulse is either in progress (with a length) or not;
  // records live in a queue bounded by DEPTH.
  bit m_init = 0;
  bit m_active;
  int m_len;
  int q[$];
  int m_evt;
  bit m_stuck, m_ovf;

  always @(posedge clk) begin
    bit pop, push, set_stuck;
    int plen;
    if (rst) begin
      m_init = 1; m_active = 0; m_len = 0; q.delete();
      m_evt = 0; m_stuck = 0; m_ovf = 0;
    end else begin
      pop = (q.size() > 0) && (rif.rec_ready === 1'b1);
      push = 0; set_stuck = 0; plen = 0;
      if (!m_active) begin
        if (en && y) begin
          m_active = 1; m_len = 1;
          if (TIMEOUT == 1) set_stuck = 1;
        end
      end else if (y) begin
        if (m_len < LMAX && m_len + 1 == TIMEOUT) set_stuck = 1;
        if (m_len < LMAX) m_len++;
      end else begin
        push = 1; plen = m_len; m_active = 0; m_len = 0;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(plen);
        else if (!clr) m_ovf = 1;
        if (!clr && m_evt < CMAX) m_evt++;
      end
      if (clr) begin m_evt = 0; m_stuck = 0; m_ovf = 0; end
      else if (set_stuck) m_stuck = 1;
    end
  end

  // Cycle-by-cycle comparison on the inactive edge
  always @(negedge clk) begin
    if (m_init) begin
      chk("m_rec_valid", rif.rec_valid, (q.size() > 0) ? 1 : 0);
      chk("m_rec_len",   rif.rec_len,   (q.size() > 0) ? q[0] : 0);
      chk("m_evt_count", evt_count,     m_evt);
      chk("m_stuck",     stuck,         m_stuck);
      chk("m_overflow",  overflow,      m_ovf);
      chk("m_fifo_full", fifo_full,     (q.size() == DEPTH) ? 1 : 0);
    end
  end

  // One clock with the given en/y; inputs change #1 after the edge
  task automatic cyc(input logic e, input logic yy);
    en = e; y = yy;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int n);
    repeat (n) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
  endtask

  task automatic pop1();
    rif.rec_ready = 1'b1;
    cyc(1'b0, 1'b0);
    rif.rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rif.rec_ready = 1'b0;
    do_reset();
    chk("rst_valid", rif.rec_valid, 0);
    chk("rst_len",   rif.rec_len,   0);
    chk("rst_evt",   evt_count,     0);
    chk("rst_flags", {stuck, overflow, fifo_full}, 0);

    // 1: single 3-sample pulse
    pulse(3);
    chk("t1_valid", rif.rec_valid, 1);
    chk("t1_len",   rif.rec_len,   3);
    chk("t1_evt",   evt_count,     1);
    chk("t1_stuck", stuck,         0);

    // 2: fill FIFO, then overflow, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      pulse(i);
      if (i == 4) begin
        chk("t2_full4", fifo_full, 1);
        chk("t2_ovf4",  overflow,  0);
      end
    end
    chk("t2_ovf5", overflow,  1);
    chk("t2_evt5", evt_count, 5);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_valid", rif.rec_valid, 1);
      chk("t2_drain_len",   rif.rec_len,   i);
      pop1();
    end
    chk("t2_empty", rif.rec_valid, 0);

    // 3: stuck at the 200th sample, length saturates
    do_reset();
    repeat (199) cyc(1'b1, 1'b1);
    chk("t3_stuck199", stuck, 0);
    cyc(1'b1, 1'b1);
    chk("t3_stuck200", stuck, 1);
    repeat (100) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("t3_len_sat", rif.rec_len, 255);
    chk("t3_evt",     evt_count,   1);
    clr = 1'b1;
    cyc(1'b0, 1'b0);
    clr = 1'b0;
    chk("t3_clr_stuck", stuck,     0);
    chk("t3_clr_evt",   evt_count, 0);
    pop1();
    pulse(150);
    chk("t3_len150",  rif.rec_len, 150);
    chk("t3_stuck_n", stuck,       0);
    chk("t3_evt150",  evt_count,   1);

    // 4: full FIFO, pop and push at the same edge
    do_reset();
    for (int i = 1; i <= 4; i++) pulse(i);
    repeat (5) cyc(1'b1, 1'b1);
    rif.rec_ready = 1'b1;
    cyc(1'b1, 1'b0);
    rif.rec_ready = 1'b0;
    chk("t4_ovf",  overflow,    0);
    chk("t4_full", fifo_full,   1);
    chk("t4_head", rif.rec_len, 2);
    chk("t4_evt",  evt_count,   5);
    for (int i = 2; i <= 5; i++) begin
      chk("t4_drain_len", rif.rec_len, i);
      pop1();
    end

    // 5: clr on the falling edge; en=0 blocks a start; level-triggered start
    do_reset();
    repeat (2) cyc(1'b1, 1'b1);
    clr = 1'b1;
    cyc(1'b1, 1'b0);
    clr = 1'b0;
    chk("t5_clr_evt", evt_count,   0);
    chk("t5_rec",     rif.rec_len, 2);
    pop1();
    repeat (5) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("t5_en0_valid", rif.rec_valid, 0);
    chk("t5_en0_evt",   evt_count,     0);
    repeat (5) cyc(1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("t5_level_len", rif.rec_len, 2);
    chk("t5_level_evt", evt_count,   1);

    // 6: reset mid-pulse discards it
    do_reset();
    repeat (4) cyc(1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    chk("t6_rst_valid", rif.rec_valid, 0);
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("t6_len", rif.rec_len, 3);
    chk("t6_evt", evt_count,   1);

    repeat (2) cyc(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_pulse_logger.md
Name: fsm_pulse_logger

Overview:
Downstream monitor for the pattern-detect FSM's registered output y. It measures each high pulse of y in clock cycles and counts completed pulses. It flags a stuck-high condition and queues per-pulse length records in a small FIFO, which a consumer drains through a valid/ready handshake.

Parameters:
LEN_W, 8, width of the pulse-length counter and record; saturates at 2^LEN_W-1
CNT_W, 16, width of the completed-pulse counter; saturates at 2^CNT_W-1
DEPTH, 4, record FIFO depth; power of 2, minimum 2
TIMEOUT, 200, consecutive high samples that trigger stuck; legal range 1..2^LEN_W-1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  enables the start of new pulse measurement
y_in  in  1  FSM output y, already registered in the clk domain
clr  in  1  synchronous clear of evt_count, stuck and overflow
rec_valid  out  1  FIFO non-empty
rec_ready  in  1  consumer accepts the head record
rec_len  out  LEN_W  head record: pulse length in cycles
evt_count  out  CNT_W  completed pulses since reset or clr
stuck  out  1  sticky: a pulse reached TIMEOUT samples
overflow  out  1  sticky: a record was dropped because the FIFO was full
fifo_full  out  1  FIFO holds DEPTH records

Behaviour:
- Reset (rst=1 at a rising edge; overrides everything):
  - State is IDLE and len=0.
  - FIFO is empty: rec_valid=0, fifo_full=0, rec_len=0.
  - evt_count=0, stuck=0, overflow=0.
- Reset mid-pulse discards the pulse: no record is pushed and evt_count is unchanged from 0.
- Pulse length is the number of consecutive rising edges at which y_in is sampled 1.
- States:
  - IDLE: if en=1 and y_in=1, go to HIGH with len=1. This is level-triggered, so a y_in already high when en rises starts a pulse. Otherwise stay in IDLE.
  - HIGH, y_in=1: len increments, saturating at 2^LEN_W-1. If the new len equals TIMEOUT, go to STUCK and set stuck=1 at the same edge. With TIMEOUT=1, the IDLE->HIGH edge goes directly to STUCK.
  - HIGH, y_in=0: push len, increment evt_count (saturating), go to IDLE.
  - STUCK, y_in=1: len keeps incrementing, saturating.
  - STUCK, y_in=0: push len, increment evt_count, go to IDLE.
- en=0 does not interrupt HIGH or STUCK; measurement always runs to the falling sample.
- No back-to-back pulse start: the edge that ends a pulse returns to IDLE. A new pulse can start at the next edge, so a single 0 sample separates records.
- FIFO behaviour:
  - First-word fall-through: rec_len is the head whenever rec_valid=1, and rec_len=0 when the FIFO is empty.
  - Latency: a record pushed at edge t is visible on rec_valid/rec_len after edge t when the FIFO was empty.
  - A pop occurs at an edge with rec_valid=1 and rec_ready=1. rec_ready while empty is ignored.
  - Push when full and no pop: the record is dropped, overflow is set, and evt_count still increments.
  - Push when full with a simultaneous pop: both happen, with no drop and no overflow.
  - Push and pop when not full: both happen and the occupancy is unchanged.
  - Order is strict FIFO. Pointers wrap modulo DEPTH, with an occupancy counter of width log2(DEPTH)+1.
- clr:
  - Zeroes evt_count, stuck and overflow at that edge.
  - Has priority over a same-edge increment or set, so the result is 0.
  - Does not flush the FIFO and does not affect the state machine or len.
- All outputs are registered or driven directly from registers; there is no combinational path from inputs to outputs.

Test Plan:
1. rst then en=1, y_in=1 for 3 samples then 0 -> at the falling-sample edge, one record is pushed. Next cycle: rec_valid=1, rec_len=3, evt_count=1, stuck=0.
2. rec_ready=0, five pulses of lengths 1,2,3,4,5 -> fifo_full=1 after the 4th and overflow=1 after the 5th. evt_count=5. Draining yields 1,2,3,4, then rec_valid=0.
3. y_in high for 300 samples -> stuck=1 from the edge of the 200th high sample. Record rec_len=255 (saturated) and evt_count=1. A 150-sample pulse after clr gives rec_len=150 with stuck=0.
4. FIFO full with rec_ready=1 held while a pulse ends -> the pop and push happen together. overflow stays 0, fifo_full stays 1, and the head advances.
5. clr asserted at the same edge a pulse ends -> evt_count=0 and the record is still pushed. en=0 with y_in high -> no record and the state stays IDLE.
6. rst asserted during the 5th sample of a pulse while y_in stays 1 and en=1 -> no record for the old pulse. A new pulse starts the edge after rst deasserts; on its fall, rec_len counts only samples after reset and evt_count=1.
